ines_loader: RTL and testbench

Sequencer that loads an iNES image from a byte stream into the program/character ROM array before the CPU and PPU start. It validates the 16-byte header on the fly against the supported NROM profile, then issues sequential write commands for header, PRG and CHR bytes at ROM byte offsets 0x0000–0x600F. It holds the CPU in reset until the image is complete, and reports errors with a code. It sits between the host/SD byte source and the ROM's programming port.

---
 rtl/nes_rom_pkg.sv | 36 +++
 rtl/ines_header_check.sv | 51 +++++
 rtl/ines_loader.sv | 168 ++++++++++++++++
 tb/tb_ines_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_rom_pkg.sv
// rtl/nes_rom_pkg.sv - iNES/NROM image constants, loader state and error code types
package nes_rom_pkg;

  localparam int HDR_BYTES      = 16;
  localparam int TRAINER_BYTES  = 512;
  localparam int PRG_BANK_BYTES = 16384;
  localparam int CHR_BANK_BYTES = 8192;
  localparam int ROM_BYTES      = 'h6010;

  // "NES" followed by MS-DOS EOF; header byte 0 sits in bits [7:0]
  localparam logic [31:0] INES_MAGIC = 32'h1A53_454E;

  typedef enum logic [2:0] {
    LS_IDLE  = 3'd0,
    LS_HDR   = 3'd1,
    LS_SKIP  = 3'd2,
    LS_PRG   = 3'd3,
    LS_CHR   = 3'd4,
    LS_DONE  = 3'd5,
    LS_ERROR = 3'd6
  } loader_state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_MAGIC   = 3'd1,
    ERR_PRG     = 3'd2,
    ERR_CHR     = 3'd3,
    ERR_MAPPER  = 3'd4,
    ERR_TRAINER = 3'd5
  } ines_err_t;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    return INES_MAGIC[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ines_header_check.sv
// rtl/ines_header_check.sv - per-byte iNES header rules for the NROM profile (option: INES_TRAINER_SKIP_EN)
module ines_header_check
  import nes_rom_pkg::*;
#(
  parameter int PRG_BANKS = 1,
  parameter int CHR_BANKS = 1
) (
  input  logic [3:0] idx,
  input  logic [7:0] data,
  output logic       ok,
  output logic [2:0] err_code,
  output logic       trainer
);

  ines_err_t code;

  // Classify one header byte; mapper nibble is checked before the trainer bit
  always_comb begin
    code    = ERR_NONE;
    trainer = 1'b0;
    case (idx)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        if (data != magic_byte(idx[1:0])) code = ERR_MAGIC;
      end
      4'd4: begin
        if (data != 8'(PRG_BANKS)) code = ERR_PRG;
      end
      4'd5: begin
        if (data != 8'(CHR_BANKS)) code = ERR_CHR;
      end
      4'd6: begin
        if (data[7:4] != 4'd0) begin
          code = ERR_MAPPER;
        end else if (data[2]) begin
          trainer = 1'b1;
`ifndef INES_TRAINER_SKIP_EN
          code = ERR_TRAINER;
`endif
        end
      end
      4'd7: begin
        if (data[7:4] != 4'd0) code = ERR_MAPPER;
      end
      default: ;
    endcase
  end

  assign err_code = code;
  assign ok       = (code == ERR_NONE);

endmodule

// File: rtl/ines_loader.sv
// rtl/ines_loader.sv - iNES NROM image loader: header validation and ROM write sequencing (option: INES_TRAINER_SKIP_EN)
module ines_loader
  import nes_rom_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int PRG_BANKS = 1,
  parameter int CHR_BANKS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic              cpu_hold
);

  localparam logic [2:0] S_IDLE  = LS_IDLE;
  localparam logic [2:0] S_HDR   = LS_HDR;
  localparam logic [2:0] S_PRG   = LS_PRG;
  localparam logic [2:0] S_CHR   = LS_CHR;
  localparam logic [2:0] S_DONE  = LS_DONE;
  localparam logic [2:0] S_ERROR = LS_ERROR;
`ifdef INES_TRAINER_SKIP_EN
  localparam logic [2:0] S_SKIP  = LS_SKIP;
`endif

  // Last ROM offset of each region; the trainer never occupies address space
  localparam logic [ADDR_W-1:0] HDR_LAST = ADDR_W'(HDR_BYTES - 1);
  localparam logic [ADDR_W-1:0] PRG_LAST =
    ADDR_W'(HDR_BYTES + PRG_BANKS * PRG_BANK_BYTES - 1);
  localparam logic [ADDR_W-1:0] CHR_LAST =
    ADDR_W'(HDR_BYTES + PRG_BANKS * PRG_BANK_BYTES + CHR_BANKS * CHR_BANK_BYTES - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic              do_write;
  logic              start_load;
  logic              hc_ok;
  logic [2:0]        hc_code;
  logic              hc_trainer;

`ifdef INES_TRAINER_SKIP_EN
  logic [8:0] skip_cnt;
  logic       trainer_flag;
`else
  logic unused_trainer;
  assign unused_trainer = hc_trainer;
`endif

  ines_header_check #(
    .PRG_BANKS (PRG_BANKS),
    .CHR_BANKS (CHR_BANKS)
  ) u_hdr_check (
    .idx      (addr[3:0]),
    .data     (in_data),
    .ok       (hc_ok),
    .err_code (hc_code),
    .trainer  (hc_trainer)
  );

  // Stream is accepted only while a data-consuming state is active
  always_comb begin
    in_ready = (state == S_HDR) || (state == S_PRG) || (state == S_CHR);
`ifdef INES_TRAINER_SKIP_EN
    if (state == S_SKIP) in_ready = 1'b1;
`endif
  end

  assign busy       = in_ready;
  assign accept     = in_valid & in_ready;
  assign start_load = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign do_write   = accept && ((state == S_HDR && hc_ok) || state == S_PRG || state == S_CHR);
  assign cpu_hold   = ~done;

  // Registered ROM write port and the running ROM offset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'd0;
      addr    <= '0;
    end else begin
      wr_en <= do_write;
      if (do_write) begin
        wr_addr <= addr;
        wr_data <= in_data;
      end
      if (start_load) begin
        addr <= '0;
      end else if (do_write) begin
        addr <= addr + 1'b1;
      end
    end
  end

  // Load sequencer: header check, optional trainer skip, PRG then CHR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 3'd0;
`ifdef INES_TRAINER_SKIP_EN
      skip_cnt     <= 9'd0;
      trainer_flag <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state    <= S_HDR;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 3'd0;
`ifdef INES_TRAINER_SKIP_EN
            skip_cnt     <= 9'd0;
            trainer_flag <= 1'b0;
`endif
          end
        end
        S_HDR: begin
          if (accept) begin
            if (!hc_ok) begin
              state    <= S_ERROR;
              err      <= 1'b1;
              err_code <= hc_code;
            end else begin
`ifdef INES_TRAINER_SKIP_EN
              if (hc_trainer) trainer_flag <= 1'b1;
              if (addr == HDR_LAST) state <= trainer_flag ? S_SKIP : S_PRG;
`else
              if (addr == HDR_LAST) state <= S_PRG;
`endif
            end
          end
        end
`ifdef INES_TRAINER_SKIP_EN
        S_SKIP: begin
          if (accept) begin
            skip_cnt <= skip_cnt + 9'd1;
            if (skip_cnt == 9'(TRAINER_BYTES - 1)) state <= S_PRG;
          end
        end
`endif
        S_PRG: begin
          if (accept && addr == PRG_LAST) state <= S_CHR;
        end
        S_CHR: begin
          if (accept && addr == CHR_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ines_loader.sv
// tb/tb_ines_loader.sv - scoreboard bench for ines_loader (option: INES_TRAINER_SKIP_EN)
module tb_ines_loader;

  localparam int IMG_BYTES = 24592;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  err_code;
  logic        cpu_hold;

  int vectors = 0;
  int miscompares = 0;
  int writes = 0;
  logic [22:0] sb_q[$];
  logic [14:0] exp_addr = 15'd0;

  ines_loader #(.ADDR_W(15), .PRG_BANKS(1), .CHR_BANKS(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hdr_byte(input int i);
    case (i)
      0: return 8'h4E;
      1: return 8'h45;
      2: return 8'h53;
      3: return 8'h1A;
      4: return 8'h01;
      5: return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] img_byte(input int i);
    if (i < 16) return hdr_byte(i);
    return 8'((i * 37) ^ (i >> 8));
  endfunction

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; presents one byte and returns at the next falling edge
  task automatic send_byte(input logic [7:0] b, input bit expect_write);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout: got 0, expected 1 (exp_addr 0x%0h)", exp_addr);
      summary();
      $finish;
    end
    if (expect_write) begin
      sb_q.push_back({exp_addr, b});
      exp_addr++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = 15'd0;
  endtask

  task automatic run_err(input int idx, input logic [7:0] val, input logic [2:0] code);
    pulse_start();
    for (int j = 0; j < idx; j++) send_byte(hdr_byte(j), 1'b1);
    send_byte(val, 1'b0);
    chk("err_set", 32'(err), 32'd1);
    chk("err_code", 32'(err_code), 32'(code));
    chk("err_in_ready", 32'(in_ready), 32'd0);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_cpu_hold", 32'(cpu_hold), 32'd1);
    in_valid = 1'b1;
    in_data  = hdr_byte(idx);
    repeat (3) @(negedge clk);
    chk("err_in_ready_held", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    chk("err_sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin : monitor
    logic [22:0] e;
    if (rst && wr_en) begin
      writes++;
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        e = sb_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          miscompares++;
          $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                   wr_addr, wr_data, e[22:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    vectors++;
    miscompares++;
    $display("FAIL watchdog: got timeout, expected completion");
    summary();
    $finish;
  end

  initial begin
    int w0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    rst = 1'b1;
    @(negedge clk);

    // Full continuous image; a garbage byte offered with start must not be consumed
    w0 = writes;
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    exp_addr = 15'd0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("in_ready_hdr", 32'(in_ready), 32'd1);
    for (int i = 0; i < IMG_BYTES; i++) send_byte(img_byte(i), 1'b1);
    chk("done_after_last", 32'(done), 32'd1);
    chk("cpu_hold_released", 32'(cpu_hold), 32'd0);
    chk("busy_after_last", 32'(busy), 32'd0);
    chk("last_wr_en", 32'(wr_en), 32'd1);
    chk("last_wr_addr", 32'(wr_addr), 32'h600F);
    chk("in_ready_done", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("wr_en_single", 32'(wr_en), 32'd0);
    chk("done_sticky", 32'(done), 32'd1);
    chk("sb_drained_full", 32'(sb_q.size()), 32'd0);
    chk("write_count_full", 32'(writes - w0), 32'(IMG_BYTES));

    // Header failures
    run_err(3, 8'h1B, 3'd1);
    chk("done_cleared", 32'(done), 32'd0);
    run_err(4, 8'h02, 3'd2);
    run_err(6, 8'h10, 3'd4);
    run_err(6, 8'h14, 3'd4);
`ifndef INES_TRAINER_SKIP_EN
    run_err(6, 8'h04, 3'd5);
`else
    // Trainer skip: 512 bytes swallowed, PRG starts at 0x10
    w0 = writes;
    pulse_start();
    for (int j = 0; j < 16; j++) send_byte((j == 6) ? 8'h04 : hdr_byte(j), 1'b1);
    for (int j = 0; j < 512; j++) send_byte(8'(j), 1'b0);
    for (int j = 0; j < 4; j++) send_byte(img_byte(16 + j), 1'b1);
    @(negedge clk);
    chk("trainer_busy", 32'(busy), 32'd1);
    chk("trainer_err", 32'(err), 32'd0);
    chk("trainer_sb_drained", 32'(sb_q.size()), 32'd0);
    chk("trainer_write_count", 32'(writes - w0), 32'd20);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
`endif

    // Asynchronous reset partway through a load
    pulse_start();
    for (int i = 0; i < 'h3000; i++) send_byte(img_byte(i), 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_err_code", 32'(err_code), 32'd0);
    chk("arst_wr_addr", 32'(wr_addr), 32'd0);
    chk("arst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("arst_sb_drained", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reload with in_valid gaps and a start pulse while busy
    w0 = writes;
    pulse_start();
    for (int i = 0; i < IMG_BYTES; i++) begin
      if (i % 13 == 5) begin
        in_valid = 1'b0;
        repeat ((i % 3) + 1) @(negedge clk);
      end
      if (i == 5000) start = 1'b1;
      send_byte(img_byte(i), 1'b1);
      start = 1'b0;
    end
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_last_addr", 32'(wr_addr), 32'h600F);
    chk("gap_cpu_hold", 32'(cpu_hold), 32'd0);
    @(negedge clk);
    chk("gap_sb_drained", 32'(sb_q.size()), 32'd0);
    chk("gap_write_count", 32'(writes - w0), 32'(IMG_BYTES));

    summary();
    $finish;
  end

endmodule
